adc_tone_pattern_gen: RTL and testbench
=======================================

// Module: adc_tone_pattern_gen
// PURPOSE
//  Synthesisable multi-tone ADC stimulus source: replaces the raw ADC input of the
//  SDR receiver chain with a sum of TONES programmable sinusoids, a ramp, DC or noise.
//  Sits between adc_dat_a_i capture and the receiver/waterfall DDCs.
//  Used for in-system loopback and for bit-exact bench stimulus.
//  Output is an AXI4-Stream master with backpressure.
// PARAMETERS
//  TONES          2   number of summed tones (1..8)
//  DATA_WIDTH     16  output sample width, two's complement
//  PHASE_WIDTH    32  phase accumulator width
//  LUT_ADDR_WIDTH 10  log2 sine-table depth (top bits of phase index the table)
//  AMP_WIDTH      16  per-tone unsigned amplitude, Q0.AMP_WIDTH; must be >= DATA_WIDTH-1
// PORTS
//  aclk           in   1                    clock; all logic on rising edge
//  aresetn        in   1                    async assert, active-low reset
//  enable         in   1                    1 = generate samples
//  cfg_mode       in   2                    0 tones, 1 ramp, 2 DC, 3 LFSR noise
//  cfg_phase_inc  in   TONES*PHASE_WIDTH    per-tone increment, tone k at [k*PW +: PW]
//  cfg_amp        in   TONES*AMP_WIDTH      per-tone amplitude, tone k at [k*AW +: AW]
//  cfg_update     in   1                    pulse: latch cfg_* into shadow registers
//  cfg_phase_rst  in   1                    with cfg_update: zero all accumulators
//  m_axis_tdata   out  DATA_WIDTH           sample
//  m_axis_tvalid  out  1                    sample valid
//  m_axis_tready  in   1                    downstream accept
// BEHAVIOUR
//  Reset: accumulators, shadow cfg, pipeline regs = 0.
//   LFSR = 32'h0000_0001; m_axis_tdata = 0; m_axis_tvalid = 0.
//  ce = !m_axis_tvalid | m_axis_tready; every pipeline stage and accumulator advances only on ce.
//  Pipeline, 4 stages: S0 phase accumulate; S1 registered LUT read; S2 signed x amplitude;
//   S3 sum + saturate -> output register.
//  Valid shift-reg: enable & ce enters S0. tvalid rises on the 4th ce edge after enable first sampled high.
//  Enable low: accumulators/LFSR hold, pipeline drains. tvalid falls once empty and accepted.
//  Accumulators: acc_k <= acc_k + inc_k (mod 2^PHASE_WIDTH) on each accepted S0 step.
//   The first sample uses phase 0.
//  LUT entry i = round((2^(DW-1)-1)*sin(2*pi*i/2^LAW)).
//   Quarter-wave folding is permitted only if bit-exact to the full table.
//  Product: (lut * {1'b0,amp}) >>> AMP_WIDTH, arithmetic shift (truncation toward -inf).
//  Sum width DATA_WIDTH+clog2(TONES). Saturate to [-2^(DW-1), 2^(DW-1)-1].
//  Mode 1 ramp: output = acc_0[PW-1 -: DW] (signed), via the same latency.
//  Mode 2 DC: output = {1'b0, amp_0[AW-1 -: DW-1]}.
//  Mode 3 noise: Galois LFSR, taps 32'h8020_0003, steps on each S0 step.
//   LFSR[31 -: DW] is scaled by amp_0 like a tone.
//  cfg_update: shadow regs load at the next edge, even while stalled.
//   New values apply to the next S0 step; samples already in flight are unchanged.
//  cfg_update with cfg_phase_rst: accumulators are cleared at that edge.
//   The clear takes priority over an increment on the same edge.
//  Mode change mid-stream: no flush; in-flight samples keep their old mode tag (tag piped with valid).
//  Async reset mid-stream: all outputs go to reset values immediately; no partial sample is emitted.
//  tdata is held stable while tvalid & !tready.
// STRUCTURE
//  Package adc_tone_pkg: mode encodings (MODE_TONES/RAMP/DC/NOISE), LFSR taps/seed,
//   a clog2 function, and the LUT generation function.
//  Sub-module sine_lut_rom: one registered read port, parametrised by LAW/DW.
//   Instantiated once per tone.
//  Remainder (accumulators, multiply, adder tree, saturation, AXIS skid-free hold) is in this module.
// TESTING
//  Clock 125 MHz, defaults, tready=1.
//  1. Quarter rate: tone0 inc 0x4000_0000, amp 0xFFFF; tone1 amp 0; enable.
//     -> after 4 edges tdata repeats 0, 32766, 0, -32767.
//  2. Saturation: both tones inc 0x4000_0000, amp 0xFFFF.
//     -> sequence 0, 32767, 0, -32768; no wrap.
//  3. Backpressure: tready low for 5 cycles mid-stream.
//     -> tdata frozen, tvalid high; the sequence resumes with no dropped or duplicated sample.
//  4. 45 MHz + 5 MHz: inc 0x5C28_F5C3 / 0x0A3D_70A4, amp 0x8000 each.
//     -> 4096 outputs match the golden model bit-exact; FFT peaks at 45 and 5 MHz.
//  5. cfg_update with cfg_phase_rst while stalled.
//     -> the first post-stall S0 sample is phase 0; in-flight samples keep the old config.
//  6. Modes: DC with amp_0=0xFFFF -> 32767 constant.
//     Noise from reset -> first LFSR words match the model.
//     aresetn pulsed mid-stream -> tvalid=0, tdata=0 at once.

Source files
------------

// File: rtl/adc_tone_pkg.sv
// Shared definitions for the ADC tone pattern generator: mode tags, LFSR
// constants, and elaboration-time helpers (clog2, sine table entry).
// No ports; imported by the generator top and the sine ROM.
package adc_tone_pkg;

  typedef enum logic [1:0] {
    MODE_TONES = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_DC    = 2'd2,
    MODE_NOISE = 2'd3
  } mode_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;
  localparam real         LUT_PI    = 3.14159265358979323846;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Right-shifting Galois form: the bit shifted out selects the tap XOR.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  // round((2^(dw-1)-1) * sin(2*pi*idx/2^law)), rounding half away from zero.
  // Only ever evaluated with constant arguments to build the ROM contents.
  function automatic int lut_entry(input int idx, input int law, input int dw);
    real scale;
    real ang;
    real v;
    scale = (2.0 ** (dw - 1)) - 1.0;
    ang   = 2.0 * LUT_PI * real'(idx) / (2.0 ** law);
    v     = scale * $sin(ang);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else          return -$rtoi(0.5 - v);
  endfunction

endpackage

// File: rtl/adc_tone_pattern_gen_if.sv
// AXI4-Stream sample channel between the tone generator and its consumer.
// Ports: tdata (sample), tvalid (source has a sample), tready (sink accepts).
// master = generator side, slave = consumer side.
interface adc_tone_pattern_gen_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/sine_lut_rom.sv
// Full-period sine ROM with one registered read port.
// Latency: 1 cycle from addr to dat when en is high; dat holds while en is low.
// Ports: aclk, aresetn (async, active-low), en (advance), addr, dat (signed).
module sine_lut_rom
  import adc_tone_pkg::*;
#(
  parameter int LAW = 10,
  parameter int DW  = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 en,
  input  logic [LAW-1:0]       addr,
  output logic signed [DW-1:0] dat
);

  localparam int DEPTH = 1 << LAW;

  logic signed [DW-1:0] rom [DEPTH];

  // Table contents are elaboration constants.
  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    assign rom[i] = DW'(lut_entry(i, LAW, DW));
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) dat <= '0;
    else if (en)  dat <= rom[addr];
  end

endmodule

// File: rtl/adc_tone_pattern_gen.sv
// Multi-tone / ramp / DC / noise ADC stimulus source with an AXI4-Stream output.
// Latency: 4 clock-enabled stages (phase, LUT read, scale, sum+saturate to output register).
// Backpressure: one global enable ce = !tvalid | tready stalls every stage; tdata holds while stalled.
// Ports: aclk, aresetn, enable, cfg_mode/cfg_phase_inc/cfg_amp (shadowed on cfg_update),
//        cfg_phase_rst (with cfg_update clears accumulators), m_axis (master stream).
module adc_tone_pattern_gen
  import adc_tone_pkg::*;
#(
  parameter int TONES          = 2,
  parameter int DATA_WIDTH     = 16,
  parameter int PHASE_WIDTH    = 32,
  parameter int LUT_ADDR_WIDTH = 10,
  parameter int AMP_WIDTH      = 16
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         enable,
  input  logic [1:0]                   cfg_mode,
  input  logic [TONES*PHASE_WIDTH-1:0] cfg_phase_inc,
  input  logic [TONES*AMP_WIDTH-1:0]   cfg_amp,
  input  logic                         cfg_update,
  input  logic                         cfg_phase_rst,
  adc_tone_pattern_gen_if.master       m_axis
);

  localparam int DW  = DATA_WIDTH;
  localparam int PW  = PHASE_WIDTH;
  localparam int LAW = LUT_ADDR_WIDTH;
  localparam int AW  = AMP_WIDTH;
  localparam int MW  = DW + AW + 1;
  localparam int SW  = DW + clog2(TONES);

  localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (DW - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  // Shadow configuration and free-running state
  mode_t          sh_mode;
  logic [PW-1:0]  sh_inc [TONES];
  logic [AW-1:0]  sh_amp [TONES];
  logic [PW-1:0]  acc    [TONES];
  logic [31:0]    lfsr;

  // Pipeline registers; amplitude and mode travel with each sample so a
  // config change never alters samples already in flight.
  logic                 s0_vld, s1_vld, s2_vld, out_vld;
  mode_t                s0_mode, s1_mode, s2_mode;
  logic [LAW-1:0]       s0_addr [TONES];
  logic [AW-1:0]        s0_amp  [TONES];
  logic [AW-1:0]        s1_amp  [TONES];
  logic signed [DW-1:0] s0_aux, s1_aux, s2_aux;
  logic signed [DW-1:0] lut_dat [TONES];
  logic signed [DW-1:0] s2_prod [TONES];
  logic [DW-1:0]        out_dat;

  logic                 ce;
  logic                 step;
  logic signed [DW-1:0] aux_nxt;
  logic signed [DW-1:0] mul_in    [TONES];
  logic signed [MW-1:0] prod_full [TONES];
  logic [TONES-1:0]     prod_unused;
  logic signed [SW-1:0] sum;
  logic signed [DW-1:0] sat_dat;
  logic signed [DW-1:0] out_nxt;

  assign ce            = !out_vld || m_axis.tready;
  assign step          = ce && enable;
  assign m_axis.tdata  = out_dat;
  assign m_axis.tvalid = out_vld;

  // Non-tone modes carry their sample in a single aux lane; noise is
  // still scaled by amp_0 at the multiply stage.
  always_comb begin
    aux_nxt = lfsr[31 -: DW];
    case (sh_mode)
      MODE_RAMP: aux_nxt = acc[0][PW-1 -: DW];
      MODE_DC:   aux_nxt = {1'b0, sh_amp[0][AW-1 -: DW-1]};
      default:   ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sh_mode <= MODE_TONES;
      lfsr    <= LFSR_SEED;
      for (int k = 0; k < TONES; k++) begin
        sh_inc[k] <= '0;
        sh_amp[k] <= '0;
        acc[k]    <= '0;
      end
    end else begin
      // Shadow load ignores ce so software can reprogram while stalled.
      if (cfg_update) begin
        sh_mode <= mode_t'(cfg_mode);
        for (int k = 0; k < TONES; k++) begin
          sh_inc[k] <= cfg_phase_inc[k*PW +: PW];
          sh_amp[k] <= cfg_amp[k*AW +: AW];
        end
      end
      // The clear wins over an increment on the same edge.
      for (int k = 0; k < TONES; k++) begin
        if (cfg_update && cfg_phase_rst) acc[k] <= '0;
        else if (step)                   acc[k] <= acc[k] + sh_inc[k];
      end
      if (step) lfsr <= lfsr_next(lfsr);
    end
  end

  for (genvar k = 0; k < TONES; k++) begin : g_tone
    sine_lut_rom #(
      .LAW (LAW),
      .DW  (DW)
    ) u_rom (
      .aclk    (aclk),
      .aresetn (aresetn),
      .en      (ce),
      .addr    (s0_addr[k]),
      .dat     (lut_dat[k])
    );
  end

  // Signed sample times unsigned Q0.AW amplitude; bits [AW +: DW] are the
  // arithmetic shift right by AW, and always fit since amp < 1.0.
  always_comb begin
    for (int k = 0; k < TONES; k++) begin
      mul_in[k] = lut_dat[k];
      if (k == 0 && s1_mode == MODE_NOISE) mul_in[k] = s1_aux;
      prod_full[k]   = MW'(mul_in[k]) * MW'($signed({1'b0, s1_amp[k]}));
      prod_unused[k] = ^{prod_full[k][MW-1], prod_full[k][AW-1:0]};
    end
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < TONES; k++) sum = sum + SW'(s2_prod[k]);
    if (sum > SAT_MAX)      sat_dat = SAT_MAX[DW-1:0];
    else if (sum < SAT_MIN) sat_dat = SAT_MIN[DW-1:0];
    else                    sat_dat = sum[DW-1:0];
    case (s2_mode)
      MODE_TONES: out_nxt = sat_dat;
      MODE_NOISE: out_nxt = s2_prod[0];
      default:    out_nxt = s2_aux;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s0_vld  <= 1'b0;
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      out_vld <= 1'b0;
      s0_mode <= MODE_TONES;
      s1_mode <= MODE_TONES;
      s2_mode <= MODE_TONES;
      s0_aux  <= '0;
      s1_aux  <= '0;
      s2_aux  <= '0;
      out_dat <= '0;
      for (int k = 0; k < TONES; k++) begin
        s0_addr[k] <= '0;
        s0_amp[k]  <= '0;
        s1_amp[k]  <= '0;
        s2_prod[k] <= '0;
      end
    end else if (ce) begin
      // S0: sample the accumulators before they advance (first sample = phase 0)
      s0_vld  <= enable;
      s0_mode <= sh_mode;
      s0_aux  <= aux_nxt;
      for (int k = 0; k < TONES; k++) begin
        s0_addr[k] <= acc[k][PW-1 -: LAW];
        s0_amp[k]  <= sh_amp[k];
      end
      // S1: LUT read happens inside the ROMs
      s1_vld  <= s0_vld;
      s1_mode <= s0_mode;
      s1_aux  <= s0_aux;
      for (int k = 0; k < TONES; k++) s1_amp[k] <= s0_amp[k];
      // S2: scale
      s2_vld  <= s1_vld;
      s2_mode <= s1_mode;
      s2_aux  <= s1_aux;
      for (int k = 0; k < TONES; k++) s2_prod[k] <= prod_full[k][AW +: DW];
      // S3: sum, saturate, present
      out_vld <= s2_vld;
      out_dat <= out_nxt;
    end
  end

endmodule

// File: tb/tb_adc_tone_pattern_gen.sv
// Directed bench for adc_tone_pattern_gen: expected samples are queued as
// stimulus is set up and popped on each accepted output beat.
// Covers reset, quarter-rate tone, saturation, backpressure, bit-exact
// two-tone run, stalled phase reset, DC, async reset, LFSR noise.
module tb_adc_tone_pattern_gen;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  cfg_mode = '0;
  logic [63:0] cfg_phase_inc = '0;
  logic [31:0] cfg_amp = '0;
  logic        cfg_update = 1'b0;
  logic        cfg_phase_rst = 1'b0;
  logic        tb_rdy = 1'b1;
  logic        hold_chk = 1'b0;

  int    n_cmp = 0;
  int    n_err = 0;
  int    exp_q[$];
  string tag = "reset";
  int    pat1[4] = '{0, 32766, 0, -32767};
  int    pat2[4] = '{0, 32767, 0, -32768};

  adc_tone_pattern_gen_if #(.DATA_WIDTH(16)) axis ();
  assign axis.tready = tb_rdy;

  adc_tone_pattern_gen dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .enable        (enable),
    .cfg_mode      (cfg_mode),
    .cfg_phase_inc (cfg_phase_inc),
    .cfg_amp       (cfg_amp),
    .cfg_update    (cfg_update),
    .cfg_phase_rst (cfg_phase_rst),
    .m_axis        (axis)
  );

  always #4 aclk = ~aclk;

  // ---------------- reference model ----------------
  function automatic int ref_lut(input int idx);
    real v;
    v = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(idx) / 1024.0);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else          return -$rtoi(0.5 - v);
  endfunction

  function automatic int ref_scale(input int v, input int amp);
    longint p;
    p = longint'(v) * longint'(amp);
    return int'(p >>> 16);
  endfunction

  function automatic int ref_sat(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic push_tones(input int n, input logic [31:0] i0, input logic [31:0] i1,
                            input int a0, input int a1);
    logic [31:0] p0;
    logic [31:0] p1;
    p0 = '0;
    p1 = '0;
    for (int j = 0; j < n; j++) begin
      exp_q.push_back(ref_sat(ref_scale(ref_lut(int'(p0[31:22])), a0) +
                              ref_scale(ref_lut(int'(p1[31:22])), a1)));
      p0 = p0 + i0;
      p1 = p1 + i1;
    end
  endtask

  task automatic push_noise(input int n, input int a0);
    logic [31:0] s;
    logic [15:0] top;
    s = 32'h0000_0001;
    for (int j = 0; j < n; j++) begin
      top = s[31:16];
      exp_q.push_back(ref_scale(int'($signed(top)), a0));
      s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", name, obs, expv);
    end
  endtask

  // One clock: sample at negedge, then return at posedge+1 for driving.
  task automatic cycle();
    @(negedge aclk);
    if (axis.tvalid && axis.tready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL %s_extra: observed sample %0d, expected none", tag, $signed(axis.tdata));
      end else begin
        chk({tag, "_beat"}, $signed(axis.tdata), exp_q.pop_front());
      end
    end else if (hold_chk && !axis.tready && exp_q.size() > 0) begin
      chk({tag, "_hold_tvalid"}, axis.tvalid, 1);
      chk({tag, "_hold_tdata"}, $signed(axis.tdata), exp_q[0]);
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] mode, input logic [31:0] i0, input logic [31:0] i1,
                         input logic [15:0] a0, input logic [15:0] a1, input logic prst);
    cfg_mode      = mode;
    cfg_phase_inc = {i1, i0};
    cfg_amp       = {a1, a0};
    cfg_update    = 1'b1;
    cfg_phase_rst = prst;
    cycle();
    cfg_update    = 1'b0;
    cfg_phase_rst = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    enable = 1'b0;
    while ((axis.tvalid || exp_q.size() > 0) && t < 64) begin
      cycle();
      t++;
    end
    chk({tag, "_leftover"}, exp_q.size(), 0);
    chk({tag, "_drained_tvalid"}, axis.tvalid, 0);
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (2) @(posedge aclk);
    #1;
    chk("reset_tvalid", axis.tvalid, 0);
    chk("reset_tdata", $signed(axis.tdata), 0);
    aresetn = 1'b1;
    cycle();
    cycle();
    chk("idle_tvalid", axis.tvalid, 0);

    // Quarter-rate single tone, with fill latency
    tag = "quarter";
    set_cfg(2'd0, 32'h4000_0000, 32'h0, 16'hFFFF, 16'h0000, 1'b1);
    for (int j = 0; j < 12; j++) exp_q.push_back(pat1[j % 4]);
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (i == 2) chk("fill_tvalid_3edges", axis.tvalid, 0);
      if (i == 3) chk("fill_tvalid_4edges", axis.tvalid, 1);
    end
    drain();

    // Two full-scale tones in phase: saturates
    tag = "saturate";
    set_cfg(2'd0, 32'h4000_0000, 32'h4000_0000, 16'hFFFF, 16'hFFFF, 1'b1);
    for (int j = 0; j < 8; j++) exp_q.push_back(pat2[j % 4]);
    enable = 1'b1;
    repeat (8) cycle();
    drain();

    // Five stalled edges mid-stream: 40 enabled edges give 35 samples
    tag = "backpressure";
    set_cfg(2'd0, 32'h5C28_F5C3, 32'h0A3D_70A4, 16'h8000, 16'h8000, 1'b1);
    push_tones(35, 32'h5C28_F5C3, 32'h0A3D_70A4, 32768, 32768);
    enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 20) begin tb_rdy = 1'b0; hold_chk = 1'b1; end
      if (i == 25) begin tb_rdy = 1'b1; hold_chk = 1'b0; end
      cycle();
    end
    drain();

    // Long bit-exact two-tone run
    tag = "two_tone";
    set_cfg(2'd0, 32'h5C28_F5C3, 32'h0A3D_70A4, 16'h8000, 16'h8000, 1'b1);
    push_tones(4096, 32'h5C28_F5C3, 32'h0A3D_70A4, 32768, 32768);
    enable = 1'b1;
    repeat (4096) cycle();
    drain();

    // Reprogram + phase reset while stalled; in-flight samples keep old config
    tag = "stall_cfg";
    set_cfg(2'd0, 32'h4000_0000, 32'h0, 16'hFFFF, 16'h0000, 1'b1);
    push_tones(10, 32'h4000_0000, 32'h0, 65535, 0);
    push_tones(8, 32'h1000_0000, 32'h0800_0000, 32768, 16384);
    enable = 1'b1;
    repeat (10) cycle();
    tb_rdy = 1'b0;
    hold_chk = 1'b1;
    cycle();
    set_cfg(2'd0, 32'h1000_0000, 32'h0800_0000, 16'h8000, 16'h4000, 1'b1);
    cycle();
    tb_rdy = 1'b1;
    hold_chk = 1'b0;
    repeat (8) cycle();
    drain();

    // DC
    tag = "dc";
    set_cfg(2'd2, 32'h0, 32'h0, 16'hFFFF, 16'h0000, 1'b1);
    for (int j = 0; j < 6; j++) exp_q.push_back(32767);
    enable = 1'b1;
    repeat (6) cycle();
    drain();

    // Async reset in the middle of a DC stream
    tag = "arst";
    for (int j = 0; j < 12; j++) exp_q.push_back(32767);
    enable = 1'b1;
    repeat (8) cycle();
    chk("arst_pre_tvalid", axis.tvalid, 1);
    aresetn = 1'b0;
    #1;
    chk("arst_tvalid", axis.tvalid, 0);
    chk("arst_tdata", $signed(axis.tdata), 0);
    exp_q.delete();
    enable = 1'b0;
    cycle();
    cycle();
    aresetn = 1'b1;
    cycle();
    chk("arst_release_tvalid", axis.tvalid, 0);

    // LFSR noise from the reset seed, scaled by amp_0
    tag = "noise";
    set_cfg(2'd3, 32'h0, 32'h0, 16'hFFFF, 16'h0000, 1'b0);
    push_noise(16, 65535);
    enable = 1'b1;
    repeat (16) cycle();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
